data_mem_master: RTL and testbench

Initiator-side controller for the 8-bit single-port data memory in the MEM stage. Accepts byte and halfword load/store requests from the pipeline over a valid/ready handshake. Sequences each request into one or two byte-wide memory transactions, little-endian. Returns load data (zero- or sign-extended) or a store acknowledge on a one-cycle response strobe.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/data_mem_master.sv | 133 +++++++++++++
 tb/tb_data_mem_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory path: widths, FSM states,
// access sizes and the latched request payload.
package mem_pkg;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned MEM_DATA_W = 8;
   localparam int unsigned DATA_W     = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BYTE0 = 2'd1;
   localparam logic [1:0] ST_BYTE1 = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_HALF = 1'b1;

   typedef struct packed {
      logic              write;
      logic              size;
      logic              sgn;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Assemble a pipeline-width load result from the captured memory bytes.
   function automatic logic [DATA_W-1:0] load_extend(
      input logic                  size,
      input logic                  sgn,
      input logic [MEM_DATA_W-1:0] hi,
      input logic [MEM_DATA_W-1:0] lo
   );
      if (size == SIZE_HALF)
         return {hi, lo};
      else if (sgn)
         return {{MEM_DATA_W{lo[MEM_DATA_W-1]}}, lo};
      else
         return {{MEM_DATA_W{1'b0}}, lo};
   endfunction

endpackage

// File: rtl/data_mem_master.sv
// Initiator for the byte-wide data memory: splits byte/halfword loads and
// stores into little-endian byte transactions and returns a response strobe.
import mem_pkg::*;

module data_mem_master (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_size,
   input  logic                  req_signed,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  stall,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [MEM_DATA_W-1:0] mem_write_data,
   output logic                  mem_read_write,
   input  logic [MEM_DATA_W-1:0] mem_read_data
);

   logic [1:0]            state_q, state_d;
   mem_req_t              req_q, req_d;
   logic [MEM_DATA_W-1:0] data_lo_q, data_lo_d;
   logic [MEM_DATA_W-1:0] data_hi_q, data_hi_d;

   logic                  req_ready_d;
   logic                  stall_d;
   logic                  resp_valid_d;
   logic [DATA_W-1:0]     resp_rdata_d;
   logic [ADDR_W-1:0]     mem_address_d;
   logic [MEM_DATA_W-1:0] mem_write_data_d;
   logic                  mem_read_write_d;

   // Next state, request/data capture, and output values for the next cycle.
   always_comb begin
      state_d          = state_q;
      req_d            = req_q;
      data_lo_d        = data_lo_q;
      data_hi_d        = data_hi_q;
      req_ready_d      = 1'b0;
      stall_d          = 1'b0;
      resp_valid_d     = 1'b0;
      resp_rdata_d     = '0;
      mem_address_d    = '0;
      mem_write_data_d = '0;
      mem_read_write_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_BYTE0;
               req_d   = '{write: req_write, size: req_size, sgn: req_signed,
                           addr: req_addr, wdata: req_wdata};
            end
         end
         ST_BYTE0: begin
            if (!req_q.write)
               data_lo_d = mem_read_data;
            state_d = (req_q.size == SIZE_HALF) ? ST_BYTE1 : ST_RESP;
         end
         ST_BYTE1: begin
            if (!req_q.write)
               data_hi_d = mem_read_data;
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the state being entered so they register
      // cleanly without any path from req_* into the memory port.
      req_ready_d = (state_d == ST_IDLE);
      stall_d     = (state_d != ST_IDLE);
      case (state_d)
         ST_BYTE0: begin
            mem_address_d    = req_d.addr;
            mem_write_data_d = req_d.wdata[MEM_DATA_W-1:0];
            mem_read_write_d = req_d.write;
         end
         ST_BYTE1: begin
            mem_address_d    = ADDR_W'(req_d.addr + ADDR_W'(1));
            mem_write_data_d = req_d.wdata[DATA_W-1:MEM_DATA_W];
            mem_read_write_d = req_d.write;
         end
         ST_RESP: begin
            resp_valid_d = 1'b1;
            if (!req_d.write)
               resp_rdata_d = load_extend(req_d.size, req_d.sgn, data_hi_d, data_lo_d);
         end
         default: ;
      endcase
   end

   // FSM state, latched request and captured load bytes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         data_lo_q <= '0;
         data_hi_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         data_lo_q <= data_lo_d;
         data_hi_q <= data_hi_d;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready      <= 1'b1;
         stall          <= 1'b0;
         resp_valid     <= 1'b0;
         resp_rdata     <= '0;
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_read_write <= 1'b0;
      end else begin
         req_ready      <= req_ready_d;
         stall          <= stall_d;
         resp_valid     <= resp_valid_d;
         resp_rdata     <= resp_rdata_d;
         mem_address    <= mem_address_d;
         mem_write_data <= mem_write_data_d;
         mem_read_write <= mem_read_write_d;
      end
   end

endmodule

// File: tb/tb_data_mem_master.sv
// Bench for data_mem_master: byte-array memory, transaction-level reference
// model with a per-cycle compare, and directed load/store/reset scenarios.
module tb_data_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_size = 1'b0;
   logic        req_signed = 1'b0;
   logic [7:0]  req_addr = 8'h00;
   logic [15:0] req_wdata = 16'h0000;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        stall;
   logic [7:0]  mem_address;
   logic [7:0]  mem_write_data;
   logic        mem_read_write;
   logic [7:0]  mem_read_data;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];

   int total = 0;
   int bad = 0;

   data_mem_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_write(mem_read_write), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address];
   always @(posedge clk) if (mem_read_write) mem[mem_address] <= mem_write_data;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: cycles remaining in the current access (0 = idle).
   int          m_cnt = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          acc_cyc = 0;
   int          prev_acc_cyc = 0;
   logic        m_write = 1'b0;
   logic        m_size = 1'b0;
   logic [7:0]  m_addr = 8'h00;
   logic [15:0] m_wdata = 16'h0000;
   logic [15:0] m_exp = 16'h0000;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0;
      end else begin
         cyc++;
         if (m_cnt != 0) begin
            m_cnt--;
         end else if (req_valid) begin
            logic [7:0] a1;
            m_write = req_write;
            m_size  = req_size;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            a1 = m_addr + 8'd1;
            if (m_write) begin
               ref_mem[m_addr] = m_wdata[7:0];
               if (m_size) ref_mem[a1] = m_wdata[15:8];
               m_exp = 16'h0000;
            end else if (m_size) begin
               m_exp = {ref_mem[a1], ref_mem[m_addr]};
            end else if (req_signed) begin
               m_exp = {{8{ref_mem[m_addr][7]}}, ref_mem[m_addr]};
            end else begin
               m_exp = {8'h00, ref_mem[m_addr]};
            end
            m_cnt = m_size ? 3 : 2;
            prev_acc_cyc = acc_cyc;
            acc_cyc = cyc;
            acc_cnt++;
         end
      end
   end

   logic [15:0] last_resp = 16'h0000;
   int          last_lat = 0;

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic       busy, in_resp, in_byte, first;
      logic [7:0] a1;
      busy    = (m_cnt != 0);
      in_resp = (m_cnt == 1);
      in_byte = (m_cnt > 1);
      first   = (m_cnt == (m_size ? 3 : 2));
      a1      = m_addr + 8'd1;
      check("req_ready", 16'(req_ready), 16'(!busy));
      check("stall", 16'(stall), 16'(busy));
      check("resp_valid", 16'(resp_valid), 16'(in_resp));
      if (in_resp) check("resp_rdata", resp_rdata, m_exp);
      if (rst) check("resp_rdata_rst", resp_rdata, 16'h0000);
      check("mem_read_write", 16'(mem_read_write), 16'(in_byte && m_write));
      check("mem_address", 16'(mem_address), in_byte ? 16'(first ? m_addr : a1) : 16'h0000);
      check("mem_write_data", 16'(mem_write_data),
            in_byte ? 16'(first ? m_wdata[7:0] : m_wdata[15:8]) : 16'h0000);
      if (resp_valid) begin
         last_resp = resp_rdata;
         last_lat  = cyc - acc_cyc;
      end
   end

   task automatic wait_accept(input int start);
      int n = 0;
      while (acc_cnt == start && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (acc_cnt == start) check("accept_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_cnt != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (m_cnt != 0) check("idle_timeout", 16'd0, 16'd1);
   endtask

   task automatic set_req(input logic w, input logic s, input logic sg,
                          input logic [7:0] a, input logic [15:0] wd);
      req_write  = w;
      req_size   = s;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
   endtask

   // One request; fields are scrambled right after acceptance.
   task automatic do_req(input logic w, input logic s, input logic sg,
                         input logic [7:0] a, input logic [15:0] wd);
      int start;
      @(negedge clk); #2;
      start = acc_cnt;
      set_req(w, s, sg, a, wd);
      req_valid = 1'b1;
      wait_accept(start);
      #2;
      req_valid = 1'b0;
      set_req(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
      wait_idle();
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] saved105;
      int         start;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      mem[101]     = 8'h80;
      ref_mem[101] = 8'h80;

      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 16'(req_ready), 16'd1);

      // Byte store then unsigned byte load
      do_req(1'b1, 1'b0, 1'b0, 8'd100, 16'h33A5);
      check("mem100", 16'(mem[100]), 16'h00A5);
      do_req(1'b0, 1'b0, 1'b0, 8'd100, 16'h0000);
      check("ld100", last_resp, 16'h00A5);
      check("byte_lat", 16'(last_lat), 16'd1);

      // Sign extension
      do_req(1'b0, 1'b0, 1'b1, 8'd101, 16'h0000);
      check("ld101_s", last_resp, 16'hFF80);
      do_req(1'b0, 1'b0, 1'b0, 8'd101, 16'h0000);
      check("ld101_u", last_resp, 16'h0080);

      // Halfword round trip
      do_req(1'b1, 1'b1, 1'b0, 8'd102, 16'h1234);
      check("mem102", 16'(mem[102]), 16'h0034);
      check("mem103", 16'(mem[103]), 16'h0012);
      do_req(1'b0, 1'b1, 1'b0, 8'd102, 16'h0000);
      check("ld102_h", last_resp, 16'h1234);
      check("half_lat", 16'(last_lat), 16'd2);

      // Signed flag has no effect on halfword loads
      do_req(1'b0, 1'b1, 1'b1, 8'd101, 16'h0000);
      check("ld101_h_s", last_resp, 16'h3480);

      // Address wrap
      do_req(1'b1, 1'b1, 1'b0, 8'hFF, 16'hBEEF);
      check("mem255", 16'(mem[255]), 16'h00EF);
      check("mem0", 16'(mem[0]), 16'h00BE);
      do_req(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000);
      check("ld_wrap", last_resp, 16'hBEEF);

      // req_valid held across two requests
      @(negedge clk); #2;
      start = acc_cnt;
      set_req(1'b0, 1'b0, 1'b0, 8'd100, 16'h0000);
      req_valid = 1'b1;
      wait_accept(start);
      #2;
      set_req(1'b1, 1'b0, 1'b0, 8'd110, 16'h0077);
      wait_accept(start + 1);
      check("b2b_gap", 16'(acc_cyc - prev_acc_cyc), 16'd3);
      #2 req_valid = 1'b0;
      wait_idle();
      check("b2b_mem110", 16'(mem[110]), 16'h0077);
      do_req(1'b0, 1'b0, 1'b0, 8'd110, 16'h0000);
      check("ld110", last_resp, 16'h0077);

      // Reset while the second byte of a halfword store is pending
      saved105 = mem[105];
      @(negedge clk); #2;
      start = acc_cnt;
      set_req(1'b1, 1'b1, 1'b0, 8'd104, 16'h5566);
      req_valid = 1'b1;
      wait_accept(start);
      #2 req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      ref_mem[105] = saved105;
      #1;
      check("rst_rw_now", 16'(mem_read_write), 16'd0);
      check("rst_stall_now", 16'(stall), 16'd0);
      check("rst_ready_now", 16'(req_ready), 16'd1);
      check("rst_resp_now", 16'(resp_valid), 16'd0);
      check("rst_rdata_now", resp_rdata, 16'h0000);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      check("mem104", 16'(mem[104]), 16'h0066);
      check("mem105", 16'(mem[105]), 16'(saved105));
      do_req(1'b0, 1'b1, 1'b0, 8'd104, 16'h0000);
      check("ld104_h", last_resp, {saved105, 8'h66});
      check("ld104_lit", last_resp, 16'hE266);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
